// File: rtl/uart_bus_ctrl_pkg.sv
// Shared definitions for the UART bus controller.
//   - CPU-visible register addresses (TXD, RXD, CON)
//   - CON bit positions
//   - TX sequencer state type
package uart_bus_ctrl_pkg;

    localparam logic [31:0] UART_TXD = 32'h4000_0018;
    localparam logic [31:0] UART_RXD = 32'h4000_001C;
    localparam logic [31:0] UART_CON = 32'h4000_0020;

    localparam int unsigned CON_TX_IRQ_EN = 0;
    localparam int unsigned CON_RX_IRQ_EN = 1;
    localparam int unsigned CON_TX_DONE   = 2;
    localparam int unsigned CON_RX_VALID  = 3;
    localparam int unsigned CON_TX_BUSY   = 4;
    localparam int unsigned CON_RX_OVRN   = 5;
    localparam int unsigned CON_TX_FULL   = 6;
    localparam int unsigned CON_TX_DROP   = 7;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_PULSE     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_bus_ctrl_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes waiting for the UART core.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset (flushes pointers)
//   push_i, wdata_i    write request and data
//   pop_i              read request; rdata_o is the current head (show-ahead)
//   full_o, empty_o    status
//   count_o            number of stored entries
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: CPU-side front end for the UART core.
// Ports:
//   sysclk, reset_n          clock, synchronous active-low reset
//   addr, rd_en, wr_en,      CPU load/store interface; decodes TXD/RXD/CON only
//   wdata, rdata             (rdata is combinational, 0 when not decoded)
//   irq                      registered level interrupt
//   tx_data, tx_enable       byte and one-cycle send pulse to the core
//   tx_status                core TX idle (slow domain, synchronized here)
//   rx_data, rx_status       received byte and byte-valid (slow domain)
module uart_bus_ctrl
    import uart_bus_ctrl_pkg::*;
#(
    parameter int unsigned TX_DEPTH     = 4,
    parameter int unsigned BUSY_TIMEOUT = 2047
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_status,
    input  logic [7:0]  rx_data,
    input  logic        rx_status
);

    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

    logic        hit_txd, hit_rxd, hit_con;
    logic        txd_push, rxd_rd_fx, con_rd_fx, con_wr;
    logic [1:0]  tx_sync_q, rx_sync_q;
    logic        rx_prev_q, rx_rise, tx_idle_s;
    tx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic [$clog2(TX_DEPTH):0] fifo_count;
    logic        set_tx_done, tx_drop_evt, tx_busy;
    logic [1:0]  irq_en_q;
    logic        tx_done_q, rx_valid_q, rx_ovrn_q, tx_drop_q, irq_q;
    logic [7:0]  rx_hold_q;
    logic [7:0]  con_val;
    logic        unused_bits;

    assign unused_bits = ^{wdata[31:8], fifo_count};

    assign hit_txd = (addr == UART_TXD);
    assign hit_rxd = (addr == UART_RXD);
    assign hit_con = (addr == UART_CON);

    // A simultaneous store suppresses the side effects of the load.
    assign txd_push  = wr_en & hit_txd;
    assign con_wr    = wr_en & hit_con;
    assign rxd_rd_fx = rd_en & ~wr_en & hit_rxd;
    assign con_rd_fx = rd_en & ~wr_en & hit_con;

    assign tx_idle_s = tx_sync_q[1];
    assign rx_rise   = rx_sync_q[1] & ~rx_prev_q;
    assign tx_busy   = (state_q != TX_IDLE) | ~fifo_empty;
    assign tx_drop_evt = txd_push & fifo_full & ~fifo_pop;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_ni  (reset_n),
        .push_i  (txd_push),
        .wdata_i (wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        con_val = '0;
        con_val[CON_TX_IRQ_EN] = irq_en_q[0];
        con_val[CON_RX_IRQ_EN] = irq_en_q[1];
        con_val[CON_TX_DONE]   = tx_done_q;
        con_val[CON_RX_VALID]  = rx_valid_q;
        con_val[CON_TX_BUSY]   = tx_busy;
        con_val[CON_RX_OVRN]   = rx_ovrn_q;
        con_val[CON_TX_FULL]   = fifo_full;
        con_val[CON_TX_DROP]   = tx_drop_q;
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (hit_rxd)      rdata = {24'b0, rx_hold_q};
            else if (hit_con) rdata = {24'b0, con_val};
        end
    end

    // TX sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        fifo_pop    = 1'b0;
        set_tx_done = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_head;
                    state_d   = TX_PULSE;
                end
            end
            TX_PULSE: begin
                cnt_d   = '0;
                state_d = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (!tx_idle_s) begin
                    state_d = TX_WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    state_d     = TX_IDLE;
                    set_tx_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_WAIT_DONE: begin
                if (tx_idle_s) begin
                    state_d     = TX_IDLE;
                    set_tx_done = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_enable = (state_q == TX_PULSE);
    assign tx_data   = tx_data_q;
    assign irq       = irq_q;

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_sync_q  <= '1;
            rx_sync_q  <= '0;
            rx_prev_q  <= 1'b0;
            irq_en_q   <= '0;
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovrn_q  <= 1'b0;
            tx_drop_q  <= 1'b0;
            rx_hold_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_sync_q <= {tx_sync_q[0], tx_status};
            rx_sync_q <= {rx_sync_q[0], rx_status};
            rx_prev_q <= rx_sync_q[1];

            if (con_wr) irq_en_q <= wdata[1:0];

            // New events win over read-to-clear in the same cycle.
            if (set_tx_done)    tx_done_q <= 1'b1;
            else if (con_rd_fx) tx_done_q <= 1'b0;

            if (tx_drop_evt)    tx_drop_q <= 1'b1;
            else if (con_rd_fx) tx_drop_q <= 1'b0;

            // rx_data is stable for a full baud period around rx_status,
            // so sampling it at the synchronized edge is safe.
            if (rx_rise) begin
                rx_hold_q  <= rx_data;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !rxd_rd_fx) rx_ovrn_q <= 1'b1;
                else if (con_rd_fx)           rx_ovrn_q <= 1'b0;
            end else begin
                if (rxd_rd_fx) rx_valid_q <= 1'b0;
                if (con_rd_fx) rx_ovrn_q  <= 1'b0;
            end

            irq_q <= (irq_en_q[0] & tx_done_q) | (irq_en_q[1] & rx_valid_q);
        end
    end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
module tb_uart_bus_ctrl;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 2047;

    logic        sysclk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic        rd_en, wr_en;
    logic [31:0] wdata, rdata;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_status;
    logic [7:0]  rx_data;
    logic        rx_status;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural core model state
    logic [7:0] emitted[$];
    int  pulses = 0;
    int  core_delay = 650;
    int  core_hold = 50;
    bit  core_stuck = 1'b0;

    always #5 sysclk = ~sysclk;

    uart_bus_ctrl #(
        .TX_DEPTH     (DEPTH),
        .BUSY_TIMEOUT (TIMEOUT)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .tx_status (tx_status),
        .rx_data   (rx_data),
        .rx_status (rx_status)
    );

    // UART core: records every send pulse, then (unless stuck) goes busy
    // core_delay cycles later for core_hold cycles.
    initial begin : core_model
        tx_status = 1'b1;
        forever begin
            @(negedge sysclk);
            if (tx_enable === 1'b1) begin
                emitted.push_back(tx_data);
                pulses++;
                if (!core_stuck) begin
                    repeat (core_delay) @(negedge sysclk);
                    tx_status = 1'b0;
                    repeat (core_hold) @(negedge sysclk);
                    tx_status = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk);
        addr = a; wdata = d; wr_en = 1'b1;
        @(posedge sysclk);
        #1 wr_en = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge sysclk);
        addr = a; rd_en = 1'b1;
        #1 d = rdata;
        @(posedge sysclk);
        #1 rd_en = 1'b0; addr = '0;
    endtask

    task automatic cpu_rdwr(input logic [31:0] a, input logic [31:0] dw, output logic [31:0] d);
        @(negedge sysclk);
        addr = a; wdata = dw; rd_en = 1'b1; wr_en = 1'b1;
        #1 d = rdata;
        @(posedge sysclk);
        #1 rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int hi, input int lo);
        @(negedge sysclk);
        rx_data = b; rx_status = 1'b1;
        repeat (hi) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (lo) @(negedge sysclk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge sysclk);
        reset_n = 1'b1;
        @(negedge sysclk);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b expected 0", irq); end
        tests_run++;
        if (tx_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_enable: got %b expected 0", tx_enable); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        cpu_read(A_CON, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_con: got %h expected 0", d); end
        cpu_read(A_TXD, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL txd_read_zero: got %h expected 0", d); end
        cpu_read(32'h4000_0024, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL undecoded_read: got %h expected 0", d); end
    endtask

    task automatic test_single_tx;
        logic [31:0] d;
        int n;
        int p0;
        emitted.delete();
        p0 = pulses;
        core_stuck = 1'b0; core_delay = 650; core_hold = 50;
        cpu_write(A_CON, 32'h1);
        cpu_write(A_TXD, 32'hFFFF_FF41);
        repeat (300) @(negedge sysclk);
        cpu_read(A_CON, d);
        tests_run++;
        if (d[4] !== 1'b1 || d[2] !== 1'b0) begin
            tests_failed++; $display("FAIL single_busy_mid: got con=%h expected bit4=1 bit2=0", d);
        end
        n = 0;
        while (irq !== 1'b1 && n < 2000) begin @(negedge sysclk); n++; end
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL single_irq: got %b expected 1", irq); end
        tests_run++;
        if (pulses - p0 !== 1) begin tests_failed++; $display("FAIL single_pulses: got %0d expected 1", pulses - p0); end
        tests_run++;
        if (emitted.size() != 1 || emitted[0] !== 8'h41) begin
            tests_failed++; $display("FAIL single_byte: got size=%0d expected one byte 41", emitted.size());
        end
        tests_run++;
        if (tx_data !== 8'h41) begin tests_failed++; $display("FAIL single_tx_data_held: got %h expected 41", tx_data); end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[2] !== 1'b1 || d[4] !== 1'b0) begin
            tests_failed++; $display("FAIL single_done_set: got con=%h expected bit2=1 bit4=0", d);
        end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[2] !== 1'b0) begin tests_failed++; $display("FAIL single_done_clear: got con=%h expected bit2=0", d); end
        repeat (2) @(negedge sysclk);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL single_irq_clear: got %b expected 0", irq); end
        cpu_write(A_CON, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [7:0]  b[6];
        logic [7:0]  exp_q[$];
        int n;
        emitted.delete();
        core_stuck = 1'b0;
        core_delay = 300 + int'($urandom_range(0, 100));
        core_hold  = 20;
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        // Core stays busy: one byte leaves the FIFO, DEPTH more fit, the rest drop.
        for (int i = 0; i < 5; i++) begin
            cpu_write(A_TXD, {24'($urandom), b[i]});
            if (i < DEPTH + 1) exp_q.push_back(b[i]);
        end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[6] !== 1'b1 || d[7] !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_full_nodrop: got con=%h expected bit6=1 bit7=0", d);
        end
        cpu_write(A_TXD, {24'h0, b[5]});
        cpu_read(A_CON, d);
        tests_run++;
        if (d[7] !== 1'b1 || d[6] !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_drop: got con=%h expected bit7=1 bit6=1", d);
        end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[7] !== 1'b0) begin tests_failed++; $display("FAIL b2b_drop_clear: got con=%h expected bit7=0", d); end
        n = 0;
        while (emitted.size() < exp_q.size() && n < 6 * (core_delay + core_hold + 20)) begin
            @(negedge sysclk); n++;
        end
        repeat (core_delay + core_hold + 20) @(negedge sysclk);
        tests_run++;
        if (emitted.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL b2b_count: got %0d expected %0d", emitted.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < emitted.size(); i++) begin
            tests_run++;
            if (emitted[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, emitted[i], exp_q[i]);
            end
        end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[4] !== 1'b0 || d[2] !== 1'b1 || d[6] !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_final_con: got con=%h expected bit4=0 bit2=1 bit6=0", d);
        end
    endtask

    task automatic test_rx;
        logic [31:0] d;
        int n;
        cpu_write(A_CON, 32'h2);
        @(negedge sysclk);
        rx_data = 8'h5A; rx_status = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 8) begin @(negedge sysclk); n++; end
        tests_run++;
        if (irq !== 1'b1 || n > 4) begin
            tests_failed++; $display("FAIL rx_irq_latency: got irq=%b after %0d cycles expected 1 within 4", irq, n);
        end
        // Load and store to RXD together: read side effect must not happen.
        cpu_rdwr(A_RXD, 32'h0, d);
        cpu_read(A_CON, d);
        tests_run++;
        if (d[3] !== 1'b1) begin tests_failed++; $display("FAIL rx_rdwr_keeps_valid: got con=%h expected bit3=1", d); end
        repeat (640) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (10) @(negedge sysclk);
        cpu_read(A_RXD, d);
        tests_run++;
        if (d !== 32'h0000_005A) begin tests_failed++; $display("FAIL rx_data: got %h expected 5a", d); end
        repeat (2) @(negedge sysclk);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[3] !== 1'b0 || d[1:0] !== 2'b10) begin
            tests_failed++; $display("FAIL rx_con_after_read: got con=%h expected bit3=0 en=10", d);
        end
        cpu_write(A_CON, 32'h0);
    endtask

    task automatic test_rx_overrun;
        logic [31:0] d;
        logic [7:0]  last;
        int nb;
        for (int it = 0; it < 6; it++) begin
            nb = (it == 0) ? 2 : int'($urandom_range(1, 3));
            last = 8'h00;
            for (int k = 0; k < nb; k++) begin
                if (it == 0) last = (k == 0) ? 8'h11 : 8'h22;
                else         last = 8'($urandom);
                rx_byte(last, 20 + int'($urandom_range(0, 20)), 20);
            end
            cpu_read(A_RXD, d);
            tests_run++;
            if (d !== {24'h0, last}) begin
                tests_failed++; $display("FAIL ovr_rxd[%0d]: got %h expected %h", it, d, last);
            end
            cpu_read(A_CON, d);
            tests_run++;
            if (d[5] !== (nb > 1) || d[3] !== 1'b0) begin
                tests_failed++; $display("FAIL ovr_flag[%0d]: got con=%h expected bit5=%0d bit3=0", it, d, nb > 1);
            end
            cpu_read(A_CON, d);
            tests_run++;
            if (d[5] !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear[%0d]: got con=%h expected bit5=0", it, d); end
        end
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        logic [7:0]  b1, b2;
        int n;
        emitted.delete();
        core_stuck = 1'b1;
        b1 = 8'($urandom); b2 = 8'($urandom);
        cpu_write(A_CON, 32'h1);
        cpu_write(A_TXD, {24'h0, b1});
        n = 0;
        while (tx_enable !== 1'b1 && n < 20) begin @(negedge sysclk); n++; end
        n = 0;
        while (irq !== 1'b1 && n < TIMEOUT + 50) begin @(negedge sysclk); n++; end
        tests_run++;
        if (n < TIMEOUT || n > TIMEOUT + 4) begin
            tests_failed++; $display("FAIL timeout_len: got %0d cycles expected %0d..%0d", n, TIMEOUT, TIMEOUT + 4);
        end
        tests_run++;
        if (emitted.size() != 1 || emitted[0] !== b1) begin
            tests_failed++; $display("FAIL timeout_byte: got size=%0d expected one byte %h", emitted.size(), b1);
        end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[2] !== 1'b1 || d[4] !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_done: got con=%h expected bit2=1 bit4=0", d);
        end
        core_stuck = 1'b0;
        core_delay = int'($urandom_range(100, 300));
        core_hold  = 30;
        cpu_write(A_TXD, {24'h0, b2});
        n = 0;
        while (emitted.size() < 2 && n < 50) begin @(negedge sysclk); n++; end
        n = 0;
        while (irq !== 1'b1 && n < 1000) begin @(negedge sysclk); n++; end
        tests_run++;
        if (emitted.size() != 2 || emitted[1] !== b2 || irq !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_next: got size=%0d irq=%b expected 2 bytes last %h irq=1", emitted.size(), irq, b2);
        end
        cpu_read(A_CON, d);
        cpu_write(A_CON, 32'h0);
    endtask

    task automatic test_reset_mid_send;
        logic [31:0] d;
        int p0, p1;
        emitted.delete();
        core_stuck = 1'b0; core_delay = 300; core_hold = 20;
        p0 = pulses;
        for (int i = 0; i < 4; i++) cpu_write(A_TXD, 32'($urandom));
        repeat (50) @(negedge sysclk);
        tests_run++;
        if (pulses - p0 !== 1) begin tests_failed++; $display("FAIL midrst_first_pulse: got %0d expected 1", pulses - p0); end
        reset_n = 1'b0;
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        @(negedge sysclk);
        p1 = pulses;
        cpu_read(A_CON, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL midrst_con: got %h expected 0", d); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL midrst_tx_data: got %h expected 00", tx_data); end
        repeat (1500) @(negedge sysclk);
        tests_run++;
        if (pulses !== p1) begin tests_failed++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses - p1); end
        cpu_read(A_CON, d);
        tests_run++;
        if (d[2] !== 1'b0 || d[4] !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_not_reported: got con=%h expected bit2=0 bit4=0", d);
        end
    endtask

    initial begin
        addr = '0; wdata = '0; rd_en = 1'b0; wr_en = 1'b0;
        rx_data = '0; rx_status = 1'b0; reset_n = 1'b0;
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_rx();
        test_rx_overrun();
        test_timeout();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
